// File: rtl/square_share_arb_pkg.sv
// Shared constants for the 3-bit squarer family: operand, result and
// requester-id widths used by the squarer and by the arbiter around it.
package square_share_arb_pkg;

  localparam int OP_W  = 3;  // squarer operand width
  localparam int RES_W = 6;  // squarer result width (7*7 = 49 fits)
  localparam int ID_W  = 3;  // requester index width (up to 8 requesters)

endpackage : square_share_arb_pkg

// File: rtl/square_share_arb_square_3bits.sv
// Purely combinational 3-bit squarer: y = a*a, zero-extended to 6 bits.
module square_3bits
  import square_share_arb_pkg::*;
(
  input  logic [OP_W-1:0]  a,
  output logic [RES_W-1:0] y
);

  // Widen before multiplying so the product is not truncated to 3 bits.
  assign y = RES_W'(a) * RES_W'(a);

endmodule : square_3bits

// File: rtl/square_share_arb.sv
// Round-robin arbiter that shares one 3-bit squarer among NREQ requesters.
// A grant is issued only when the single-entry result register is free
// (empty, or being drained this cycle); the winner's operand is squared and
// registered together with its index one cycle later.
module square_share_arb
  import square_share_arb_pkg::*;
#(
  parameter int NREQ = 4  // legal range 2..8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [OP_W*NREQ-1:0] in_flat,
  output logic [NREQ-1:0]      gnt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RES_W-1:0]     out_y,
  output logic [ID_W-1:0]      out_id
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr_q,       ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [RES_W-1:0] out_y_q,     out_y_d;
  logic [ID_W-1:0]  out_id_q,    out_id_d;

  logic             slot_free;
  logic             any_gnt;
  logic [NREQ-1:0]  gnt_c;
  logic [ID_W-1:0]  win_id;
  logic [OP_W-1:0]  win_op;
  logic [RES_W-1:0] sq;
  int               idx;

  // Priority search starting at ptr, wrapping modulo NREQ; first requester wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    gnt_c     = '0;
    win_id    = '0;
    any_gnt   = 1'b0;
    idx       = 0;
    slot_free = !out_valid_q || out_ready;
    if (!rst && slot_free) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!any_gnt && req[idx]) begin
          any_gnt    = 1'b1;
          gnt_c[idx] = 1'b1;
          win_id     = ID_W'(idx);
        end
      end
    end
  end

  // One-hot AND-OR mux: only the granted requester's operand reaches the squarer.
  always_comb begin
    win_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_c[i]) win_op = win_op | in_flat[OP_W*i +: OP_W];
    end
  end

  square_3bits u_square (
    .a (win_op),
    .y (sq)
  );

  // Next-state for the result register and round-robin pointer.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_id_d    = out_id_q;
    if (any_gnt) begin
      out_valid_d = 1'b1;
      out_y_d     = sq;
      out_id_d    = win_id;
      if (int'(win_id) == NREQ - 1) ptr_d = '0;
      else                          ptr_d = PTR_W'(win_id) + PTR_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State register with synchronous reset; a held result is discarded on reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_id_q    <= out_id_d;
    end
  end

  assign gnt       = gnt_c;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_id    = out_id_q;

endmodule : square_share_arb

// File: tb/tb_square_share_arb.sv
// Directed bench for square_share_arb (NREQ=4): reset, single request,
// round robin, backpressure, pointer wrap/drain and reset during a stall.
module tb_square_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] in_flat;
  logic [3:0]  gnt;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_y;
  logic [2:0]  out_id;

  int checks = 0;
  int errors = 0;

  square_share_arb #(.NREQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in_flat   (in_flat),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the registered result triple.
  task automatic check_out(input string tag, input logic v, input logic [5:0] y, input logic [2:0] id);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".y"},     32'(out_y),     32'(y));
    check({tag, ".id"},    32'(out_id),    32'(id));
  endtask

  logic [3:0] rr_gnt [5];
  logic [5:0] rr_y   [5];

  initial begin
    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_y   = '{6'd1, 6'd4, 6'd9, 6'd49, 6'd1};

    // Reset held two cycles with all requesters asking.
    rst = 1'b1; req = 4'b1111; in_flat = '0; out_ready = 1'b1;
    tick();
    check("rst.gnt0", 32'(gnt), 32'h0);
    tick();
    check("rst.gnt1", 32'(gnt), 32'h0);
    check_out("rst", 1'b0, 6'd0, 3'd0);

    // Single request from id 2 (operand 5); other operands must be ignored.
    rst = 1'b0; req = 4'b0100; in_flat = {3'd7, 3'd5, 3'd7, 3'd7};
    #1;
    check("single.gnt", 32'(gnt), 32'b0100);
    tick();
    req = 4'b0000;
    #1;
    check("single.gnt_off", 32'(gnt), 32'h0);
    check_out("single", 1'b1, 6'd25, 3'd2);
    tick();
    check("single.drain", 32'(out_valid), 32'h0);

    // Re-reset so the pointer starts at 0, then full round robin.
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 4'b1111; in_flat = {3'd7, 3'd3, 3'd2, 3'd1};
    #1;
    check("rr.gnt0", 32'(gnt), 32'(rr_gnt[0]));
    for (int i = 1; i < 5; i++) begin
      tick();
      check_out($sformatf("rr%0d", i - 1), 1'b1, rr_y[i-1], 3'((i - 1) % 4));
      check($sformatf("rr.gnt%0d", i), 32'(gnt), 32'(rr_gnt[i]));
    end
    tick();
    check_out("rr4", 1'b1, 6'd1, 3'd0);

    // Backpressure: id 1 squares 6 -> 36, then out_ready low for 3 cycles.
    req = 4'b0010; in_flat = {3'd4, 3'd0, 3'd6, 3'd2};
    #1;
    check("bp.gnt_id1", 32'(gnt), 32'b0010);
    tick();
    out_ready = 1'b0; req = 4'b1001;
    #1;
    check("bp.gnt_stall", 32'(gnt), 32'h0);
    check_out("bp.hold", 1'b1, 6'd36, 3'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("bp.hold%0d", i), 1'b1, 6'd36, 3'd1);
      check($sformatf("bp.gnt%0d", i), 32'(gnt), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release", 32'(gnt), 32'b1000);
    tick();
    check_out("bp.id3", 1'b1, 6'd16, 3'd3);

    // Wrap: grant id 2 (operand 3 -> 9) to leave ptr at 3, then req 1001.
    req = 4'b0100; in_flat = {3'd4, 3'd3, 3'd6, 3'd2};
    #1;
    check("wrap.gnt_id2", 32'(gnt), 32'b0100);
    tick();
    check_out("wrap.id2", 1'b1, 6'd9, 3'd2);
    req = 4'b1001;
    #1;
    check("wrap.gnt_id3", 32'(gnt), 32'b1000);
    tick();
    check_out("wrap.id3", 1'b1, 6'd16, 3'd3);
    check("wrap.gnt_id0", 32'(gnt), 32'b0001);
    tick();
    check_out("wrap.id0", 1'b1, 6'd4, 3'd0);
    req = 4'b0000;
    #1;
    check("drain.gnt", 32'(gnt), 32'h0);
    tick();
    check("drain.valid", 32'(out_valid), 32'h0);

    // Reset during a stall: held result is discarded, pointer returns to 0.
    req = 4'b0010;
    #1;
    check("rstall.gnt", 32'(gnt), 32'b0010);
    tick();
    check_out("rstall.load", 1'b1, 6'd36, 3'd1);
    out_ready = 1'b0; req = 4'b0000; rst = 1'b1;
    #1;
    check("rstall.gnt_rst", 32'(gnt), 32'h0);
    tick();
    check_out("rstall.cleared", 1'b0, 6'd0, 3'd0);
    rst = 1'b0; req = 4'b1111;
    #1;
    check("rstall.first_gnt", 32'(gnt), 32'b0001);
    tick();
    check_out("rstall.after", 1'b1, 6'd4, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_square_share_arb
